// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared definitions for the memory access unit.
//   - FSM state encoding
//   - funct3 load/store size and sign constants
//   - store mask/data helpers and the misalignment predicate
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } state_e;

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;

    // funct3[1:0] encodes access size; funct3[2] selects zero-extension on loads.
    localparam logic [1:0] SzByte = 2'b00;
    localparam logic [1:0] SzHalf = 2'b01;

    function automatic logic [3:0] store_mask(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] m;
        case (sz)
            SzByte:  m = 4'b0001 << off;
            SzHalf:  m = 4'b0011 << off;  // off=3 truncates to the top lane only
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] wdata);
        logic [31:0] d;
        case (sz)
            SzByte:  d = {4{wdata[7:0]}};
            SzHalf:  d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        logic r;
        case (sz)
            SzByte:  r = 1'b0;
            SzHalf:  r = off[0];
            default: r = (off != 2'b00);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext: combinational load lane selection and sign/zero extension.
// Ports:
//   funct3_i  load size/sign (LB, LH, LW, LBU, LHU)
//   off_i     byte offset within the word (address bits [1:0])
//   rdata_i   raw word returned by memory
//   data_o    extended load result
module mem_load_ext
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata_i >> {off_i, 3'b000};
        case (funct3_i[1:0])
            SzByte:  data_o = funct3_i[2] ? {24'b0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            SzHalf:  data_o = funct3_i[2] ? {16'b0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: LSU stage between EXU and WBU.
// Accepts one op at a time (in_valid/in_ready), issues at most one memory request
// (mem_req_valid/mem_req_ready), waits for mem_rsp_valid, then presents the result
// (out_valid/out_ready). ALU-only ops bypass memory with one-cycle latency.
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   in_*                  upstream op: handshake, read/write, address, store data,
//                         funct3, ALU result and writeback passthrough
//   mem_req_*, mem_we, mem_addr, mem_wdata, mem_wmask   memory request channel
//   mem_rsp_valid, mem_rdata                            memory response channel
//   out_*                 downstream result to WBU
// Build option: define MEM_ACCESS_MISALIGN_CHECK_EN to fault misaligned half/word
// accesses (no memory access, out_misalign=1, out_data=address).
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_wdata,
    input  logic [2:0]        in_funct3,
    input  logic [31:0]       in_alu_result,
    input  logic [4:0]        in_rd_addr,
    input  logic              in_reg_write,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [4:0]        out_rd_addr,
    output logic              out_reg_write,
    output logic              out_misalign
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       data_q, data_d;
    logic [4:0]        rd_q, rd_d;
    logic              reg_write_q, reg_write_d;
    logic              store_q, store_d;

    logic        mem_op;
    logic        accept;
    logic        misalign_in;
    logic [31:0] load_data;

    assign mem_op = in_mem_read | in_mem_write;
    assign accept = (state_q == StIdle) & in_valid;

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    assign misalign_in  = mem_op & is_misaligned(in_funct3[1:0], in_addr[1:0]);
    assign out_misalign = misalign_q;

    always_comb begin
        misalign_d = misalign_q;
        if (accept) misalign_d = misalign_in;
    end

    always_ff @(posedge clk) begin
        if (!rst) misalign_q <= 1'b0;
        else      misalign_q <= misalign_d;
    end
`else
    assign misalign_in  = 1'b0;
    assign out_misalign = 1'b0;
`endif

    mem_load_ext u_load_ext (
        .funct3_i (funct3_q),
        .off_i    (addr_q[1:0]),
        .rdata_i  (mem_rdata),
        .data_o   (load_data)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        data_d      = data_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        store_d     = store_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    addr_d      = in_addr;
                    wdata_d     = in_wdata;
                    funct3_d    = in_funct3;
                    rd_d        = in_rd_addr;
                    // Write wins when both read and write are requested.
                    store_d     = in_mem_write;
                    reg_write_d = in_reg_write & ~in_mem_write & ~misalign_in;
                    data_d      = misalign_in ? 32'(in_addr) : in_alu_result;
                    state_d     = (mem_op && !misalign_in) ? StReq : StDone;
                end
            end
            StReq: begin
                if (mem_req_ready) begin
                    // A response in the grant cycle skips WAIT entirely.
                    if (mem_rsp_valid) begin
                        if (!store_q) data_d = load_data;
                        state_d = StDone;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (mem_rsp_valid) begin
                    if (!store_q) data_d = load_data;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            data_q      <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            store_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            data_q      <= data_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            store_q     <= store_d;
        end
    end

    assign in_ready      = (state_q == StIdle);
    assign mem_req_valid = (state_q == StReq);
    assign mem_we        = store_q & (state_q == StReq);
    assign mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata     = store_data(funct3_q[1:0], wdata_q);
    assign mem_wmask     = store_q ? store_mask(funct3_q[1:0], addr_q[1:0]) : 4'b0000;
    assign out_valid     = (state_q == StDone);
    assign out_data      = data_q;
    assign out_rd_addr   = rd_q;
    assign out_reg_write = reg_write_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// transactions checked against an arithmetic reference model.
module tb_mem_access_unit;

    localparam int unsigned AW = 32;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    localparam bit MisEn = 1'b1;
`else
    localparam bit MisEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0, in_ready;
    logic          in_mem_read = 1'b0, in_mem_write = 1'b0;
    logic [AW-1:0] in_addr = '0;
    logic [31:0]   in_wdata = '0, in_alu_result = '0;
    logic [2:0]    in_funct3 = '0;
    logic [4:0]    in_rd_addr = '0;
    logic          in_reg_write = 1'b0;
    logic          mem_req_valid, mem_req_ready = 1'b0, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wmask;
    logic          mem_rsp_valid = 1'b0;
    logic [31:0]   mem_rdata = '0;
    logic          out_valid, out_ready = 1'b0;
    logic [31:0]   out_data;
    logic [4:0]    out_rd_addr;
    logic          out_reg_write, out_misalign;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_mem_read   (in_mem_read),
        .in_mem_write  (in_mem_write),
        .in_addr       (in_addr),
        .in_wdata      (in_wdata),
        .in_funct3     (in_funct3),
        .in_alu_result (in_alu_result),
        .in_rd_addr    (in_rd_addr),
        .in_reg_write  (in_reg_write),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_rd_addr   (out_rd_addr),
        .out_reg_write (out_reg_write),
        .out_misalign  (out_misalign)
    );

    // ---------------- reference model ----------------
    function automatic int unsigned size_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] exp_mask(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned n = size_bytes(f3);
        int unsigned m;
        if (n == 4) return 4'hF;
        m = ((32'd1 << n) - 1) << (addr % 4);
        return 4'(m & 15);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] w);
        int unsigned n = size_bytes(f3);
        if (n == 1) return (w & 32'hFF) * 32'h0101_0101;
        if (n == 2) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int unsigned bits = 8 * size_bytes(f3);
        logic [31:0] v;
        if (bits == 32) return rdata;
        v = (rdata >> (8 * (addr % 4))) & ((32'd1 << bits) - 1);
        if (f3[2] == 1'b0 && ((v >> (bits - 1)) & 1) == 1) v = v - (32'd1 << bits);
        return v;
    endfunction

    function automatic bit exp_misalign(input logic [2:0] f3, input logic [31:0] addr);
        return (addr % size_bytes(f3)) != 0;
    endfunction

    // Runs one transaction starting at a negedge with the DUT idle; ends at a negedge.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] f3,
                           input logic [31:0] alu, input logic [4:0] rda, input bit rw,
                           input logic [31:0] rdata, input int req_dly, input int rsp_dly,
                           input int out_dly, input string name);
        bit          memop = rd | wr;
        bit          store = wr;
        bit          mis   = MisEn && memop && exp_misalign(f3, addr);
        logic [31:0] e_data;
        bit          e_rw;
        e_data = mis ? addr : (memop && !store) ? exp_load(f3, addr, rdata) : alu;
        e_rw   = (store || mis) ? 1'b0 : rw;

        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL %s in_ready_idle got=%b exp=1", name, in_ready);
        end
        in_valid = 1'b1; in_mem_read = rd; in_mem_write = wr; in_addr = addr;
        in_wdata = wdata; in_funct3 = f3; in_alu_result = alu; in_rd_addr = rda;
        in_reg_write = rw;
        @(negedge clk);
        in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom; in_alu_result = $urandom;
        in_funct3 = 3'($urandom); in_rd_addr = 5'($urandom); in_reg_write = 1'($urandom);

        if (memop && !mis) begin
            for (int i = 0; i <= req_dly; i++) begin
                checks += 4;
                if (mem_req_valid !== 1'b1) begin
                    errors++; $display("FAIL %s req_valid got=%b exp=1", name, mem_req_valid);
                end
                if (mem_addr !== (addr & ~32'd3)) begin
                    errors++;
                    $display("FAIL %s mem_addr got=%h exp=%h", name, mem_addr, addr & ~32'd3);
                end
                if (mem_we !== store) begin
                    errors++; $display("FAIL %s mem_we got=%b exp=%b", name, mem_we, store);
                end
                if (out_valid !== 1'b0) begin
                    errors++; $display("FAIL %s out_valid_in_req got=%b exp=0", name, out_valid);
                end
                if (store) begin
                    checks += 2;
                    if (mem_wdata !== exp_wdata(f3, wdata)) begin
                        errors++; $display("FAIL %s mem_wdata got=%h exp=%h", name, mem_wdata,
                                           exp_wdata(f3, wdata));
                    end
                    if (mem_wmask !== exp_mask(f3, addr)) begin
                        errors++; $display("FAIL %s mem_wmask got=%b exp=%b", name, mem_wmask,
                                           exp_mask(f3, addr));
                    end
                end
                if (i == req_dly) begin
                    mem_req_ready = 1'b1;
                    if (rsp_dly == 0) begin mem_rsp_valid = 1'b1; mem_rdata = rdata; end
                end else begin
                    mem_rdata = $urandom;
                end
                @(negedge clk);
            end
            mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
            for (int i = 0; i < rsp_dly; i++) begin
                checks += 2;
                if (mem_req_valid !== 1'b0) begin
                    errors++; $display("FAIL %s req_valid_wait got=%b exp=0", name, mem_req_valid);
                end
                if (out_valid !== 1'b0) begin
                    errors++; $display("FAIL %s out_valid_wait got=%b exp=0", name, out_valid);
                end
                if (i == rsp_dly - 1) begin mem_rsp_valid = 1'b1; mem_rdata = rdata; end
                else mem_rdata = $urandom;
                @(negedge clk);
            end
            mem_rsp_valid = 1'b0;
        end else if (memop) begin
            checks++;
            if (mem_req_valid !== 1'b0) begin
                errors++; $display("FAIL %s misalign_req got=%b exp=0", name, mem_req_valid);
            end
        end

        mem_rdata = $urandom;
        for (int i = 0; i <= out_dly; i++) begin
            checks += 5;
            if (out_valid !== 1'b1) begin
                errors++; $display("FAIL %s out_valid got=%b exp=1", name, out_valid);
            end
            if (out_rd_addr !== rda) begin
                errors++; $display("FAIL %s out_rd_addr got=%h exp=%h", name, out_rd_addr, rda);
            end
            if (out_reg_write !== e_rw) begin
                errors++; $display("FAIL %s out_reg_write got=%b exp=%b", name, out_reg_write, e_rw);
            end
            if (out_misalign !== mis) begin
                errors++; $display("FAIL %s out_misalign got=%b exp=%b", name, out_misalign, mis);
            end
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL %s in_ready_done got=%b exp=0", name, in_ready);
            end
            if (!store || mis) begin
                checks++;
                if (out_data !== e_data) begin
                    errors++; $display("FAIL %s out_data got=%h exp=%h", name, out_data, e_data);
                end
            end
            if (i == out_dly) out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks += 2;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL %s out_valid_after got=%b exp=0", name, out_valid);
        end
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL %s in_ready_after got=%b exp=1", name, in_ready);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b1; in_mem_read = 1'b1; in_addr = $urandom; in_alu_result = $urandom;
        repeat (2) @(negedge clk);
        checks += 11;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got=%b exp=1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got=%b exp=0", out_valid); end
        if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset req_valid got=%b exp=0", mem_req_valid); end
        if (mem_we !== 1'b0) begin errors++; $display("FAIL reset mem_we got=%b exp=0", mem_we); end
        if (mem_addr !== '0) begin errors++; $display("FAIL reset mem_addr got=%h exp=0", mem_addr); end
        if (mem_wdata !== '0) begin errors++; $display("FAIL reset mem_wdata got=%h exp=0", mem_wdata); end
        if (mem_wmask !== '0) begin errors++; $display("FAIL reset mem_wmask got=%b exp=0", mem_wmask); end
        if (out_data !== '0) begin errors++; $display("FAIL reset out_data got=%h exp=0", out_data); end
        if (out_rd_addr !== '0) begin errors++; $display("FAIL reset out_rd got=%h exp=0", out_rd_addr); end
        if (out_reg_write !== 1'b0) begin errors++; $display("FAIL reset out_rw got=%b exp=0", out_reg_write); end
        if (out_misalign !== 1'b0) begin errors++; $display("FAIL reset out_mis got=%b exp=0", out_misalign); end
        in_valid = 1'b0; in_mem_read = 1'b0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_txn(1'b0, 1'b1, 32'h8000_0003, 32'h0000_00AB, 3'b000, 32'h0, 5'd3, 1'b1,
                32'h0, 0, 0, 0, "sb_imm");
        run_txn(1'b1, 1'b0, 32'h8000_0001, 32'h0, 3'b000, 32'h0, 5'd4, 1'b1,
                32'h0000_8000, 0, 1, 0, "lb_neg");
        run_txn(1'b1, 1'b0, 32'h8000_0001, 32'h0, 3'b100, 32'h0, 5'd5, 1'b1,
                32'h0000_8000, 1, 1, 0, "lbu");
        run_txn(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 32'h0000_1234, 5'd6, 1'b1,
                32'h0, 0, 0, 0, "alu_only");
        run_txn(1'b1, 1'b0, 32'h1000_0010, 32'h0, 3'b010, 32'h0, 5'd7, 1'b1,
                32'hCAFE_F00D, 5, 2, 0, "lw_stall");
        run_txn(1'b1, 1'b0, 32'h1000_0006, 32'h0, 3'b001, 32'h0, 5'd8, 1'b1,
                32'h9ABC_1234, 0, 1, 3, "lh_out_stall");
        run_txn(1'b1, 1'b1, 32'h2000_0002, 32'h0000_BEEF, 3'b001, 32'h55, 5'd9, 1'b1,
                32'h0, 0, 2, 0, "rd_wr_store");
    endtask

    task automatic test_misalign();
        run_txn(1'b1, 1'b0, 32'h8000_0002, 32'h0, 3'b010, 32'h0, 5'd10, 1'b1,
                32'h1122_3344, 0, 1, 0, "lw_misalign");
        run_txn(1'b0, 1'b1, 32'h8000_0003, 32'h1234_5678, 3'b001, 32'h0, 5'd11, 1'b0,
                32'h0, 0, 0, 0, "sh_misalign");
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0; in_addr = 32'h3000_0000;
        in_funct3 = 3'b010; in_reg_write = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid wait_state got=%b exp=0", mem_req_valid);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid out_valid got=%b exp=0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid in_ready got=%b exp=1", in_ready); end
        mem_rsp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid stale_rsp got=%b exp=0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid idle got=%b exp=1", in_ready); end
    endtask

    task automatic test_random();
        logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int n = 0; n < 40; n++) begin
            int unsigned op = $urandom_range(0, 3);
            logic [2:0]  f3;
            if (op == 1) f3 = ld_f3[$urandom_range(0, 4)];
            else if (op == 0) f3 = 3'($urandom);
            else f3 = 3'($urandom_range(0, 2));
            run_txn(op == 1 || op == 3, op >= 2, $urandom, $urandom, f3, $urandom,
                    5'($urandom), 1'($urandom), $urandom, $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 2), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte address width.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-003 SHALL have port rst, input, 1: synchronous reset, active-low.
REQ-004 SHALL have port in_valid/in_ready, input/output, 1 each: upstream handshake from EXU.
REQ-005 SHALL have port in_mem_read/in_mem_write, input, 1 each: load/store request.
REQ-006 SHALL have ports in_addr (input, ADDR_W), in_wdata (input, 32) and in_funct3 (input, 3): address, store data and size/sign.
REQ-007 SHALL have ports in_alu_result (input, 32), in_rd_addr (input, 5) and in_reg_write (input, 1): passthrough for WBU.
REQ-008 SHALL have ports mem_req_valid (output, 1), mem_req_ready (input, 1), mem_we (output, 1), mem_addr (output, ADDR_W, word-aligned), mem_wdata (output, 32) and mem_wmask (output, 4): memory request channel.
REQ-009 SHALL have ports mem_rsp_valid (input, 1) and mem_rdata (input, 32): memory response channel.
REQ-010 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, 32), out_rd_addr (output, 5), out_reg_write (output, 1) and out_misalign (output, 1): downstream to WBU.

Function
REQ-011 SHALL implement FSM IDLE, REQ, WAIT, DONE; in_ready=1 only in IDLE.
REQ-012 IDLE, on in_valid with no memory op: SHALL latch inputs and go to DONE with out_data=in_alu_result, giving 1-cycle latency.
REQ-013 IDLE, on in_valid with a read or write: SHALL latch inputs and go to REQ.
REQ-014 REQ SHALL hold mem_req_valid=1 with stable mem_* until mem_req_ready=1, then go to WAIT.
REQ-015 WAIT SHALL go to DONE on mem_rsp_valid; for stores the mem_rdata value is ignored.
REQ-016 If mem_req_ready and mem_rsp_valid are both high in REQ, SHALL go directly to DONE.
REQ-017 DONE SHALL hold out_valid=1 with stable outputs until out_ready=1, then go to IDLE; no new input is accepted in that same cycle.
REQ-018 mem_addr SHALL be {in_addr[ADDR_W-1:2],2'b00}.
REQ-019 Store mask and data: SB gives wmask 4'b0001<<addr[1:0] with byte replicated; SH gives 4'b0011<<addr[1:0] with half replicated; SW gives 4'b1111.
REQ-020 Load: SHALL select the byte or half from mem_rdata by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-021 Loads SHALL have out_data set to the extended load data; stores SHALL drive out_reg_write=0 regardless of input.
REQ-022 If in_mem_read and in_mem_write are both set, SHALL treat the op as a store.

Reset
REQ-023 While rst=0 at posedge: SHALL set state to IDLE and drive all outputs 0, except in_ready=1 from the following cycle.
REQ-024 Reset mid-transaction SHALL abandon the transaction without a response wait, and SHALL not assert out_valid.

Configuration
REQ-025 With MEM_ACCESS_MISALIGN_CHECK_EN defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL skip the memory access, go to DONE with out_misalign=1, set out_reg_write=0 and out_data=in_addr.
REQ-026 Without the macro: out_misalign SHALL be tied 0, and misaligned accesses SHALL proceed using the masks and extraction of REQ-019 and REQ-020 with no fault.

Structure
REQ-027 Shared package SHALL hold FSM state encoding and funct3 constants (LB=000, LH=001, LW=010, LBU=100, LHU=101).
REQ-028 Load extraction/extension SHALL be a sub-module mem_load_ext, purely combinational.

Verification
REQ-029 SB addr=0x8000_0003 wdata=0x0000_00AB, ready immediate: mem_addr=0x8000_0000, wmask=4'b1000, wdata=0xABABABAB, out_reg_write=0.
REQ-030 LB addr=0x8000_0001 with rdata=0x0000_8000: out_data=0xFFFF_FF80; the same access as LBU gives 0x0000_0080.
REQ-031 With mem_req_ready held low 5 cycles: mem_req_valid and mem_addr SHALL stay stable; out_valid SHALL assert only after mem_rsp_valid.
REQ-032 ALU-only op with alu_result=0x1234 and out_ready=1: out_valid SHALL be high one cycle after acceptance with out_data=0x1234.
REQ-033 out_ready low 3 cycles in DONE: outputs SHALL stay stable and in_ready=0; in_ready=1 the cycle after the handshake.
REQ-034 LW addr=0x8000_0002 with macro defined: no mem_req_valid, out_misalign=1, out_data=0x8000_0002; rst=0 during WAIT leads to IDLE, out_valid=0.
